rho_pi_unit: RTL and testbench
==============================

RHO_PI_UNIT -- requirements
Module: rho_pi_unit

Interface
REQ-001 SHALL have parameter W, default 64, meaning lane width and slices per state; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter CW, default $clog2(W), meaning slice-counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rho_en, input, 1, mode: 1 = rho+pi, 0 = pi only (no rotation); sampled at the first accepted slice of each block.
REQ-006 SHALL have port in_valid, input, 1, meaning in_slice is valid.
REQ-007 SHALL have port in_ready, output, 1, meaning the unit accepts a slice this cycle.
REQ-008 SHALL have port in_slice, input, 25, one state slice; bit x+5y holds lane (x,y), x,y in 0..4.
REQ-009 SHALL have port out_valid, output, 1, meaning out_slice is valid.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer accepts out_slice.
REQ-011 SHALL have port out_slice, output, 25, one permuted slice, same bit layout.
REQ-012 SHALL have port out_z, output, CW, index of the slice currently on out_slice.
REQ-013 SHALL have port done, output, 1, one-cycle pulse after the last slice of a block is accepted downstream.

Function
REQ-014 SHALL have states IDLE, LOAD, DRAIN; only IDLE and LOAD assert in_ready, and only DRAIN asserts out_valid.
REQ-015 SHALL move IDLE->LOAD on an accepted slice (in_valid & in_ready), with that slice as z=0.
REQ-016 SHALL accept slices in LOAD in order z=0..W-1, one per cycle at most; the in counter increments only on acceptance.
REQ-017 SHALL, for each accepted slice z and each lane (x,y), write bit x+5y to buffer slice z'=(z+R(x,y)) mod W, bit x'+5y', with x'=y and y'=(2x+3y) mod 5.
REQ-018 SHALL use R(x,y)=0 when latched rho_en=0; otherwise R comes from the Keccak rho table below, reduced mod W by dropping high bits.
REQ-019 SHALL use R rows y=0..4, x=0..4: [0,1,62,28,27] [36,44,6,55,20] [3,10,43,25,39] [41,45,15,21,8] [18,2,61,56,14].
REQ-020 SHALL enter DRAIN on the cycle after slice W-1 is accepted, with out_valid=1 and out_z=0 in that cycle.
REQ-021 SHALL drive out_slice as buffer slice out_z in DRAIN; out_z advances only on out_valid & out_ready.
REQ-022 SHALL hold out_slice and out_z stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, on acceptance of out_z=W-1, go to IDLE, pulse done for one cycle, and assert in_ready on the next cycle.
REQ-024 SHALL not clear the buffer between blocks; the permutation is bijective, so a full LOAD overwrites every bit.
REQ-025 SHALL ignore in_valid while in DRAIN; no slice is consumed.
REQ-026 SHALL ignore changes to rho_en in the middle of a block.
REQ-027 SHALL wrap counters modulo W and add no extra cycles at wrap-around.
REQ-028 SHALL give a throughput of one slice per cycle in each phase, with a minimum block period of 2W+1 cycles.

Reset
REQ-029 SHALL, with rst_n=0 at any time, force state=IDLE, counters=0, latched rho_en=0, in_ready=0 during reset, out_valid=0, done=0, out_z=0, out_slice=0.
REQ-030 SHALL assert in_ready on the first clk edge after rst_n deasserts; buffer contents are don't-care after reset.
REQ-031 SHALL, on reset during LOAD or DRAIN, discard the partial block with no done pulse.

Verification
REQ-032 SHALL check reset: assert rst_n=0 mid-DRAIN -> out_valid=0 and done=0 immediately, in_ready=1 one cycle after release.
REQ-033 SHALL check W=64, rho_en=1, with only slice z=0 bit 1 set -> output slice 1 = 0x400 (bit 10), all other slices 0.
REQ-034 SHALL check W=8, rho_en=1, with only slice z=3 bit 2 set -> output slice 1 = bit 20 set, all other slices 0.
REQ-035 SHALL check rho_en=0, W=64, with only slice z=5 bit 7 set -> output slice 5 bit 11 set (lane (2,1)->(1,2)), all other slices 0.
REQ-036 SHALL check backpressure: random out_ready and random in_valid gaps -> in-order out_z 0..W-1, stable data while stalled, exactly one done per block, and the result matches a reference model over 100 random blocks.
REQ-037 SHALL check back-to-back blocks with in_valid held high -> second block accepted starting the cycle after done, with no stale data.

Source files
------------

// File: rtl/rho_pi_unit.sv
// Keccak rho+pi step over a serial slice stream.
// Slices are scattered into a buffer on load, then drained in order.
module rho_pi_unit #(
  parameter int W  = 64,
  parameter int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rho_en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [24:0]   in_slice,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [24:0]   out_slice,
  output logic [CW-1:0] out_z,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } state_t;

  localparam logic [5:0] ROT [25] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14
  };

  state_t        state_q, state_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          rho_q, rho_d;
  logic          done_q, done_d;
  logic          live_q;
  logic [24:0]   buf_q [W];
  logic [24:0]   buf_d [W];
  logic [CW-1:0] tgt [25];
  logic          in_acc;
  logic          out_acc;
  logic          rho_cur;

  // live_q keeps in_ready low until the first edge after reset
  assign in_ready  = live_q & ~done_q & (state_q != DRAIN);
  assign out_valid = (state_q == DRAIN);
  assign out_z     = out_cnt_q;
  assign out_slice = out_valid ? buf_q[out_cnt_q] : '0;
  assign done      = done_q;

  assign in_acc  = in_valid & in_ready;
  assign out_acc = out_valid & out_ready;
  // first slice of a block uses the live mode bit, later ones the latch
  assign rho_cur = (state_q == IDLE) ? rho_en : rho_q;

  // destination slice of each lane for the slice being accepted
  always_comb begin
    for (int l = 0; l < 25; l++) begin
      tgt[l] = in_cnt_q + (rho_cur ? ROT[l][CW-1:0] : '0);
    end
  end

  // scatter one slice: lane (x,y) -> lane (y, 2x+3y mod 5)
  always_comb begin
    buf_d = buf_q;
    if (in_acc) begin
      for (int l = 0; l < 25; l++) begin
        buf_d[tgt[l]][(l / 5) + 5 * ((2 * (l % 5) + 3 * (l / 5)) % 5)] =
          in_slice[l];
      end
    end
  end

  // next-state and counter logic
  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    rho_d     = rho_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_acc) begin
          state_d  = LOAD;
          rho_d    = rho_en;
          in_cnt_d = in_cnt_q + 1'b1;
        end
      end
      LOAD: begin
        if (in_acc) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == CW'(W - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_acc) begin
          out_cnt_d = out_cnt_q + 1'b1;
          if (out_cnt_q == CW'(W - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      rho_q     <= 1'b0;
      done_q    <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      rho_q     <= rho_d;
      done_q    <= done_d;
      live_q    <= 1'b1;
    end
  end

  // slice buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < W; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      buf_q <= buf_d;
    end
  end

endmodule

// File: tb/tb_rho_pi_unit.sv
// Directed and randomised checks for rho_pi_unit.
// W=64 instance for most checks, W=8 instance for modular rotation.
module tb_rho_pi_unit;

  localparam int NB  = 100;
  localparam int LIM = 40000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rho_en, in_valid, in_ready, out_valid, out_ready, done;
  logic [24:0] in_slice, out_slice;
  logic [5:0]  out_z;

  logic        b_rho, b_iv, b_ir, b_ov, b_or, b_done;
  logic [24:0] b_is, b_os;
  logic [2:0]  b_oz;

  always #5 clk = ~clk;

  rho_pi_unit #(.W(64)) dut (
    .clk(clk), .rst_n(rst_n), .rho_en(rho_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_slice(in_slice),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_slice(out_slice), .out_z(out_z), .done(done)
  );

  rho_pi_unit #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .rho_en(b_rho),
    .in_valid(b_iv), .in_ready(b_ir), .in_slice(b_is),
    .out_valid(b_ov), .out_ready(b_or),
    .out_slice(b_os), .out_z(b_oz), .done(b_done)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  int rt [5][5] = '{
    '{0, 1, 62, 28, 27},
    '{36, 44, 6, 55, 20},
    '{3, 10, 43, 25, 39},
    '{41, 45, 15, 21, 8},
    '{18, 2, 61, 56, 14}
  };

  logic [24:0] din  [NB][64];
  logic [24:0] dexp [NB][64];
  bit          drho [NB];
  int          acc0_cyc [NB];
  int          done_cyc [NB];

  task automatic model(input int b);
    int r, nz, nb;
    for (int z = 0; z < 64; z++) dexp[b][z] = '0;
    for (int z = 0; z < 64; z++)
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++) begin
          r  = drho[b] ? rt[y][x] : 0;
          nz = (z + r) % 64;
          nb = y + 5 * ((2 * x + 3 * y) % 5);
          if (din[b][z][x + 5 * y]) dexp[b][nz][nb] = 1'b1;
        end
  endtask

  task automatic clear_blk(input int b);
    for (int z = 0; z < 64; z++) begin
      din[b][z]  = '0;
      dexp[b][z] = '0;
    end
  endtask

  task automatic fill_rand(input int n);
    for (int b = 0; b < n; b++) begin
      drho[b] = 1'($urandom);
      for (int z = 0; z < 64; z++) din[b][z] = 25'($urandom);
      model(b);
    end
  endtask

  task automatic run(input int nb, input bit rnd);
    int pb = 0, pz = 0, cb = 0, cz = 0, dn = 0, cyc = 0;
    bit st = 0;
    logic [24:0] ps = '0;
    logic [5:0]  pzv = '0;
    while ((cb < nb || dn < nb) && cyc < LIM) begin
      @(negedge clk);
      if (pb < nb) begin
        in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_slice = din[pb][pz];
        rho_en   = (pz == 0) ? drho[pb] : 1'($urandom);
      end else begin
        in_valid = 1'b0;
        in_slice = 25'($urandom);
        rho_en   = 1'($urandom);
      end
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (st && out_valid) begin
        chk("hold_slice", 64'(out_slice), 64'(ps));
        chk("hold_z", 64'(out_z), 64'(pzv));
      end
      if (done) begin
        if (dn < NB) done_cyc[dn] = cyc;
        dn++;
        chk("done_pos", 64'(cb), 64'(dn));
      end
      if (in_valid && in_ready) begin
        if (pz == 0) acc0_cyc[pb] = cyc;
        if (pz == 63) begin
          pz = 0;
          pb++;
        end else pz++;
      end
      if (out_valid && cb >= nb) chk("spurious_valid", 64'(out_valid), 64'd0);
      if (out_valid && out_ready && cb < nb) begin
        chk("out_z", 64'(out_z), 64'(cz));
        chk("out_slice", 64'(out_slice), 64'(dexp[cb][cz]));
        if (cz == 63) begin
          cz = 0;
          cb++;
        end else cz++;
      end
      st  = out_valid & ~out_ready;
      ps  = out_slice;
      pzv = out_z;
      cyc++;
    end
    chk("timeout", 64'(cyc < LIM), 64'd1);
    chk("done_cnt", 64'(dn), 64'(nb));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    rho_en = 0; in_valid = 0; in_slice = '0; out_ready = 0;
    b_rho = 0; b_iv = 0; b_is = '0; b_or = 0;
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out_z", 64'(out_z), 64'd0);
    chk("rst_out_slice", 64'(out_slice), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_in_ready8", 64'(b_ir), 64'd1);

    // W=8: z=3 bit 2 -> slice 1 bit 20
    for (int z = 0; z < 8; z++) begin
      @(negedge clk);
      b_iv = 1'b1;
      b_rho = (z == 0) ? 1'b1 : 1'b0;
      b_is = (z == 3) ? 25'h4 : 25'h0;
      #1;
      chk("w8_in_ready", 64'(b_ir), 64'd1);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      b_iv = 1'b1;
      b_is = 25'h1ffffff;
      b_or = 1'b1;
      #1;
      chk("w8_in_blocked", 64'(b_ir), 64'd0);
      chk("w8_out_valid", 64'(b_ov), 64'd1);
      chk("w8_out_z", 64'(b_oz), 64'(k));
      chk("w8_out_slice", 64'(b_os), (k == 1) ? 64'h100000 : 64'h0);
    end
    @(negedge clk);
    b_iv = 1'b0;
    #1;
    chk("w8_done", 64'(b_done), 64'd1);
    chk("w8_done_valid", 64'(b_ov), 64'd0);
    chk("w8_done_ready", 64'(b_ir), 64'd0);
    @(negedge clk);
    #1;
    chk("w8_done_once", 64'(b_done), 64'd0);
    chk("w8_ready_again", 64'(b_ir), 64'd1);

    // W=64 rho: z=0 bit 1 -> slice 1 bit 10
    clear_blk(0);
    drho[0] = 1'b1;
    din[0][0] = 25'h2;
    dexp[0][1] = 25'h400;
    run(1, 1'b0);

    // W=64 pi only: z=5 bit 7 -> slice 5 bit 11
    clear_blk(0);
    drho[0] = 1'b0;
    din[0][5] = 25'h80;
    dexp[0][5] = 25'h800;
    run(1, 1'b0);

    // back-to-back blocks with in_valid held high
    fill_rand(2);
    run(2, 1'b0);
    chk("b2b_gap", 64'(acc0_cyc[1] - done_cyc[0]), 64'd1);
    chk("b2b_period", 64'(acc0_cyc[1] - acc0_cyc[0]), 64'd129);

    // reset in the middle of DRAIN
    for (int z = 0; z < 64; z++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_slice = 25'($urandom);
      rho_en = 1'b1;
      out_ready = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mid_pre_valid", 64'(out_valid), 64'd1);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_out_z", 64'(out_z), 64'd0);
    chk("mid_out_slice", 64'(out_slice), 64'd0);
    chk("mid_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rel_ready", 64'(in_ready), 64'd1);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("mid_no_done", 64'(done), 64'd0);
    end

    // random backpressure over many blocks
    fill_rand(NB);
    run(NB, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
